// File: rtl/axis_chirp_sequencer_if.sv
// Configuration, control and status bundle between a burst controller
// (master) and the chirp sequencer (slave).
interface axis_chirp_sequencer_if #(
    parameter int CNT_WIDTH    = 24,
    parameter int NCHIRP_WIDTH = 16
);
    logic [CNT_WIDTH-1:0]    cfg_period;
    logic [CNT_WIDTH-1:0]    cfg_ramp_len;
    logic [NCHIRP_WIDTH-1:0] cfg_nchirps;
    logic [3:0]              cfg_nfft;
    logic                    start;
    logic                    stop;
    logic                    frame_done;
    logic                    err_nsmall;

    logic                    ramp;
    logic [3:0]              nfft;
    logic                    busy;
    logic                    done;
    logic                    cfg_err;
    logic                    overrun;
    logic [NCHIRP_WIDTH-1:0] chirp_count;
    logic [15:0]             err_count;

    modport master (
        output cfg_period, cfg_ramp_len, cfg_nchirps, cfg_nfft,
        output start, stop, frame_done, err_nsmall,
        input  ramp, nfft, busy, done, cfg_err, overrun, chirp_count, err_count
    );

    modport slave (
        input  cfg_period, cfg_ramp_len, cfg_nchirps, cfg_nfft,
        input  start, stop, frame_done, err_nsmall,
        output ramp, nfft, busy, done, cfg_err, overrun, chirp_count, err_count
    );
endinterface

// File: rtl/axis_chirp_sequencer.sv
// Chirp burst sequencer: generates period-spaced ramp pulses for a burst of
// chirps, tracks outstanding framer frames and counts framer errors.
//
// state  | meaning
// S_IDLE | waiting for start; configuration checked and latched here
// S_RAMP | ramp high, timer counts down the ramp length
// S_GAP  | ramp low, timer counts down the remainder of the period
// S_DONE | one-cycle burst completion pulse
module axis_chirp_sequencer #(
    parameter int CNT_WIDTH    = 24,
    parameter int NCHIRP_WIDTH = 16
) (
    input logic                   aclk,
    input logic                   areset,
    axis_chirp_sequencer_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RAMP, S_GAP, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    period_q, period_d;
    logic [CNT_WIDTH-1:0]    ramp_len_q, ramp_len_d;
    logic [CNT_WIDTH-1:0]    timer_q, timer_d;
    logic [NCHIRP_WIDTH-1:0] nchirps_q, nchirps_d;
    logic [NCHIRP_WIDTH-1:0] chirp_count_q, chirp_count_d;
    logic [3:0]              nfft_q, nfft_d;
    logic [3:0]              pending_q, pending_d;
    logic [15:0]             err_count_q, err_count_d;
    logic                    ramp_q, ramp_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    cfg_err_q, cfg_err_d;
    logic                    overrun_q, overrun_d;

    logic                    cfg_bad;
    logic                    accept;
    logic                    ramp_entry;

    // A period not longer than the ramp would leave no gap cycle to count down.
    assign cfg_bad = (bus.cfg_ramp_len == '0) || (bus.cfg_nchirps == '0) ||
                     (bus.cfg_period <= bus.cfg_ramp_len);

    always_comb begin
        state_d       = state_q;
        period_d      = period_q;
        ramp_len_d    = ramp_len_q;
        timer_d       = timer_q;
        nchirps_d     = nchirps_q;
        chirp_count_d = chirp_count_q;
        nfft_d        = nfft_q;
        pending_d     = pending_q;
        err_count_d   = err_count_q;
        ramp_d        = ramp_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        cfg_err_d     = 1'b0;
        overrun_d     = overrun_q;
        accept        = 1'b0;
        ramp_entry    = 1'b0;

        if (busy_q && bus.err_nsmall && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end

        if (bus.stop && ((state_q == S_RAMP) || (state_q == S_GAP))) begin
            state_d = S_IDLE;
            ramp_d  = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.stop) begin
                        if (cfg_bad) begin
                            cfg_err_d = 1'b1;
                        end else begin
                            accept        = 1'b1;
                            period_d      = bus.cfg_period;
                            ramp_len_d    = bus.cfg_ramp_len;
                            nchirps_d     = bus.cfg_nchirps;
                            nfft_d        = bus.cfg_nfft;
                            timer_d       = bus.cfg_ramp_len - CNT_WIDTH'(1);
                            chirp_count_d = NCHIRP_WIDTH'(1);
                            err_count_d   = '0;
                            overrun_d     = 1'b0;
                            ramp_d        = 1'b1;
                            busy_d        = 1'b1;
                            state_d       = S_RAMP;
                        end
                    end
                end
                S_RAMP: begin
                    if (timer_q == '0) begin
                        state_d = S_GAP;
                        ramp_d  = 1'b0;
                        timer_d = period_q - ramp_len_q - CNT_WIDTH'(1);
                    end else begin
                        timer_d = timer_q - CNT_WIDTH'(1);
                    end
                end
                S_GAP: begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - CNT_WIDTH'(1);
                    end else if (chirp_count_q < nchirps_q) begin
                        ramp_entry    = 1'b1;
                        state_d       = S_RAMP;
                        ramp_d        = 1'b1;
                        chirp_count_d = chirp_count_q + NCHIRP_WIDTH'(1);
                        timer_d       = ramp_len_q - CNT_WIDTH'(1);
                        if (pending_q >= 4'd2) begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // The first ramp of a burst counts as one outstanding frame.
        if (accept) begin
            pending_d = 4'd1;
        end else if (bus.stop) begin
            pending_d = '0;
        end else if (ramp_entry && !bus.frame_done) begin
            if (pending_q != 4'hF) begin
                pending_d = pending_q + 4'd1;
            end
        end else if (!ramp_entry && bus.frame_done) begin
            if (pending_q != 4'd0) begin
                pending_d = pending_q - 4'd1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q       <= S_IDLE;
            period_q      <= '0;
            ramp_len_q    <= '0;
            timer_q       <= '0;
            nchirps_q     <= '0;
            chirp_count_q <= '0;
            nfft_q        <= '0;
            pending_q     <= '0;
            err_count_q   <= '0;
            ramp_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            period_q      <= period_d;
            ramp_len_q    <= ramp_len_d;
            timer_q       <= timer_d;
            nchirps_q     <= nchirps_d;
            chirp_count_q <= chirp_count_d;
            nfft_q        <= nfft_d;
            pending_q     <= pending_d;
            err_count_q   <= err_count_d;
            ramp_q        <= ramp_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cfg_err_q     <= cfg_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign bus.ramp        = ramp_q;
    assign bus.nfft        = nfft_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.cfg_err     = cfg_err_q;
    assign bus.overrun     = overrun_q;
    assign bus.chirp_count = chirp_count_q;
    assign bus.err_count   = err_count_q;
endmodule

// File: tb/tb_axis_chirp_sequencer.sv
// Scoreboard bench for axis_chirp_sequencer: stimulus queues expected output
// events, a negedge monitor detects events on the DUT outputs and compares.
module tb_axis_chirp_sequencer;
    localparam int CW = 24;
    localparam int NW = 16;
    localparam int EV_RISE   = 1;
    localparam int EV_FALL   = 2;
    localparam int EV_DONE   = 3;
    localparam int EV_CFGERR = 4;
    localparam int EV_IDLE   = 5;

    typedef struct {
        int kind;
        int cyc;
        int chirp;
        int nfft;
        int ovr;
        int errc;
    } ev_t;

    logic aclk = 1'b0;
    logic areset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   ref_c = 0;
    logic ramp_prev = 1'b0;
    logic busy_prev = 1'b0;
    ev_t  exp_q[$];
    int   rej_cfg[3][3] = '{'{6, 6, 2}, '{5, 0, 1}, '{10, 6, 0}};

    axis_chirp_sequencer_if #(.CNT_WIDTH(CW), .NCHIRP_WIDTH(NW)) bus ();

    axis_chirp_sequencer #(.CNT_WIDTH(CW), .NCHIRP_WIDTH(NW)) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input int chirp, input int nf,
                        input int ovr, input int errc);
        ev_t e;
        e.kind  = kind;
        e.cyc   = c;
        e.chirp = chirp;
        e.nfft  = nf;
        e.ovr   = ovr;
        e.errc  = errc;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d, expected none (cycle %0d)", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind", kind, e.kind);
            check("ev_cycle", cyc, e.cyc);
            check("ev_chirp_count", int'(bus.chirp_count), e.chirp);
            check("ev_nfft", int'(bus.nfft), e.nfft);
            check("ev_overrun", int'(bus.overrun), e.ovr);
            check("ev_err_count", int'(bus.err_count), e.errc);
        end
    endtask

    always @(negedge aclk) begin
        if (bus.ramp && !ramp_prev) observe(EV_RISE);
        if (!bus.ramp && ramp_prev) observe(EV_FALL);
        if (bus.done) begin
            observe(EV_DONE);
            check("done_busy", int'(bus.busy), 0);
            check("done_ramp", int'(bus.ramp), 0);
        end
        if (bus.cfg_err) begin
            observe(EV_CFGERR);
            check("cfg_err_busy", int'(bus.busy), 0);
        end
        if (!bus.busy && busy_prev && !bus.done) observe(EV_IDLE);
        ramp_prev = bus.ramp;
        busy_prev = bus.busy;
    end

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic arm(input int per, input int rl, input int nc, input int nf);
        @(posedge aclk);
        #1;
        bus.cfg_period   = CW'(per);
        bus.cfg_ramp_len = CW'(rl);
        bus.cfg_nchirps  = NW'(nc);
        bus.cfg_nfft     = 4'(nf);
        ref_c = cyc;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge aclk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_ramp"}, int'(bus.ramp), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_cfg_err"}, int'(bus.cfg_err), 0);
        check({tag, "_overrun"}, int'(bus.overrun), 0);
        check({tag, "_chirp_count"}, int'(bus.chirp_count), 0);
        check({tag, "_err_count"}, int'(bus.err_count), 0);
        check({tag, "_nfft"}, int'(bus.nfft), 0);
    endtask

    initial begin
        areset           = 1'b1;
        bus.cfg_period   = '0;
        bus.cfg_ramp_len = '0;
        bus.cfg_nchirps  = '0;
        bus.cfg_nfft     = '0;
        bus.start        = 1'b0;
        bus.stop         = 1'b0;
        bus.frame_done   = 1'b0;
        bus.err_nsmall   = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        areset = 1'b0;
        chk_reset("rst");

        // nominal burst, frames retired during each gap so no overrun
        arm(10, 6, 3, 8);
        push(EV_RISE, ref_c + 1,  1, 8, 0, 0);
        push(EV_FALL, ref_c + 7,  1, 8, 0, 0);
        push(EV_RISE, ref_c + 11, 2, 8, 0, 0);
        push(EV_FALL, ref_c + 17, 2, 8, 0, 0);
        push(EV_RISE, ref_c + 21, 3, 8, 0, 0);
        push(EV_FALL, ref_c + 27, 3, 8, 0, 0);
        push(EV_DONE, ref_c + 31, 3, 8, 0, 0);
        pulse_start();
        wait_to(ref_c + 8);  bus.frame_done = 1'b1;
        wait_to(ref_c + 9);  bus.frame_done = 1'b0;
        wait_to(ref_c + 18); bus.frame_done = 1'b1;
        wait_to(ref_c + 19); bus.frame_done = 1'b0;
        wait_to(ref_c + 34);
        check("nom_chirp_hold", int'(bus.chirp_count), 3);
        check("nom_busy_after", int'(bus.busy), 0);
        check("nom_queue_empty", exp_q.size(), 0);

        // rejected configurations: period<=ramp_len, ramp_len=0, nchirps=0
        for (int i = 0; i < 3; i++) begin
            arm(rej_cfg[i][0], rej_cfg[i][1], rej_cfg[i][2], 5);
            push(EV_CFGERR, ref_c + 1, 3, 8, 0, 0);
            pulse_start();
            wait_to(ref_c + 4);
            check("rej_busy", int'(bus.busy), 0);
            check("rej_nfft", int'(bus.nfft), 8);
        end
        check("rej_queue_empty", exp_q.size(), 0);

        // abort at the third ramp cycle of chirp 2
        arm(10, 6, 3, 4);
        push(EV_RISE, ref_c + 1,  1, 4, 0, 0);
        push(EV_FALL, ref_c + 7,  1, 4, 0, 0);
        push(EV_RISE, ref_c + 11, 2, 4, 0, 0);
        push(EV_FALL, ref_c + 14, 2, 4, 0, 0);
        push(EV_IDLE, ref_c + 14, 2, 4, 0, 0);
        pulse_start();
        wait_to(ref_c + 13); bus.stop = 1'b1;
        wait_to(ref_c + 14); bus.stop = 1'b0;
        wait_to(ref_c + 20);
        check("abort_chirp_count", int'(bus.chirp_count), 2);
        check("abort_queue_empty", exp_q.size(), 0);

        // overrun: four chirps, no frame_done ever
        arm(4, 2, 4, 3);
        push(EV_RISE, ref_c + 1,  1, 3, 0, 0);
        push(EV_FALL, ref_c + 3,  1, 3, 0, 0);
        push(EV_RISE, ref_c + 5,  2, 3, 0, 0);
        push(EV_FALL, ref_c + 7,  2, 3, 0, 0);
        push(EV_RISE, ref_c + 9,  3, 3, 1, 0);
        push(EV_FALL, ref_c + 11, 3, 3, 1, 0);
        push(EV_RISE, ref_c + 13, 4, 3, 1, 0);
        push(EV_FALL, ref_c + 15, 4, 3, 1, 0);
        push(EV_DONE, ref_c + 17, 4, 3, 1, 0);
        pulse_start();
        wait_to(ref_c + 20);
        check("ovr_queue_empty", exp_q.size(), 0);

        // error counting; a start with new cfg mid-burst must be ignored
        arm(20, 10, 1, 2);
        push(EV_RISE, ref_c + 1,  1, 2, 0, 0);
        push(EV_FALL, ref_c + 11, 1, 2, 0, 5);
        push(EV_DONE, ref_c + 21, 1, 2, 0, 5);
        pulse_start();
        wait_to(ref_c + 2); bus.err_nsmall = 1'b1;
        wait_to(ref_c + 7); bus.err_nsmall = 1'b0;
        wait_to(ref_c + 12);
        bus.cfg_period   = CW'(4);
        bus.cfg_ramp_len = CW'(2);
        bus.cfg_nchirps  = NW'(3);
        bus.cfg_nfft     = 4'd7;
        bus.start        = 1'b1;
        wait_to(ref_c + 13); bus.start = 1'b0;
        wait_to(ref_c + 23); bus.err_nsmall = 1'b1;
        wait_to(ref_c + 28); bus.err_nsmall = 1'b0;
        check("err_idle_no_incr", int'(bus.err_count), 5);
        check("err_nfft_kept", int'(bus.nfft), 2);
        check("err_queue_empty", exp_q.size(), 0);

        // start and stop together in IDLE: stop wins
        arm(10, 6, 3, 6);
        bus.stop = 1'b1;
        pulse_start();
        bus.stop = 1'b0;
        wait_to(ref_c + 6);
        check("startstop_busy", int'(bus.busy), 0);
        check("startstop_nfft", int'(bus.nfft), 2);

        // reset during GAP with start held high, then a clean burst
        arm(10, 6, 3, 9);
        push(EV_RISE, ref_c + 1, 1, 9, 0, 0);
        push(EV_FALL, ref_c + 7, 1, 9, 0, 0);
        push(EV_IDLE, ref_c + 9, 0, 0, 0, 0);
        pulse_start();
        wait_to(ref_c + 8);
        areset    = 1'b1;
        bus.start = 1'b1;
        wait_to(ref_c + 10);
        areset    = 1'b0;
        bus.start = 1'b0;
        chk_reset("midrst");

        arm(4, 2, 2, 1);
        push(EV_RISE, ref_c + 1, 1, 1, 0, 0);
        push(EV_FALL, ref_c + 3, 1, 1, 0, 0);
        push(EV_RISE, ref_c + 5, 2, 1, 0, 0);
        push(EV_FALL, ref_c + 7, 2, 1, 0, 0);
        push(EV_DONE, ref_c + 9, 2, 1, 0, 0);
        pulse_start();
        wait_to(ref_c + 12);
        check("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axis_chirp_sequencer.md
AXIS_CHIRP_SEQUENCER -- requirements
Module: axis_chirp_sequencer

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 24: width of the period and ramp-length counters.
REQ-002 SHALL have parameter NCHIRP_WIDTH, default 16: width of the chirp count and chirp counter.
REQ-003 SHALL have port aclk, input, 1: single clock; all logic is on its rising edge.
REQ-004 SHALL have port areset, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port cfg_period, input, CNT_WIDTH: chirp repetition period in aclk cycles.
REQ-006 SHALL have port cfg_ramp_len, input, CNT_WIDTH: ramp-high duration in aclk cycles.
REQ-007 SHALL have port cfg_nchirps, input, NCHIRP_WIDTH: number of chirps per burst.
REQ-008 SHALL have port cfg_nfft, input, 4: requested transform size exponent.
REQ-009 SHALL have port start, input, 1: burst start request, sampled every cycle.
REQ-010 SHALL have port stop, input, 1: burst abort request, sampled every cycle.
REQ-011 SHALL have port frame_done, input, 1: one-cycle pulse from the framer's tlast handshake.
REQ-012 SHALL have port err_nsmall, input, 1: framer window-too-small indication.
REQ-013 SHALL have port ramp, output, 1: registered ramp drive to the synthesizer and framer.
REQ-014 SHALL have port nfft, output, 4: latched transform size driven to the framer.
REQ-015 SHALL have ports busy (1), done (1), cfg_err (1), overrun (1), chirp_count (NCHIRP_WIDTH), err_count (16), all outputs, all registered.

Function
REQ-016 SHALL implement states IDLE, RAMP, GAP, DONE.
REQ-017 In IDLE with start=1 and stop=0, SHALL latch cfg_period, cfg_ramp_len, cfg_nchirps and cfg_nfft into shadow registers; nfft SHALL update from the shadow register only at this acceptance.
REQ-018 At acceptance, SHALL reject the configuration when cfg_ramp_len=0, cfg_nchirps=0 or cfg_period<=cfg_ramp_len: assert cfg_err for exactly one cycle, remain in IDLE, leave nfft unchanged.
REQ-019 At valid acceptance at cycle t, SHALL enter RAMP, drive ramp=1 and busy=1 from cycle t+1, clear chirp_count to 1, clear err_count and overrun.
REQ-020 SHALL hold ramp=1 for exactly ramp_len cycles, then enter GAP with ramp=0 for exactly period-ramp_len cycles; one chirp therefore spans exactly period cycles.
REQ-021 At GAP end, if chirp_count<nchirps, SHALL enter RAMP and increment chirp_count on that same edge; otherwise SHALL enter DONE.
REQ-022 DONE SHALL last one cycle with done=1, busy=0 and ramp=0, then return to IDLE; chirp_count SHALL hold its final value.
REQ-023 stop=1 in RAMP or GAP SHALL force IDLE on the next edge with ramp=0 and busy=0, and SHALL NOT assert done.
REQ-024 When start=1 and stop=1 in the same IDLE cycle, stop SHALL win and the start request SHALL be ignored.
REQ-025 start while busy SHALL be ignored, and cfg_* changes while busy SHALL have no effect.
REQ-026 SHALL keep a 4-bit pending-frame counter: +1 on each RAMP entry, -1 on each frame_done, unchanged when both occur in one cycle, saturating at 15 and at 0.
REQ-027 When RAMP is entered with pending>=2 before the update, SHALL set overrun sticky until the next valid acceptance or reset.
REQ-028 SHALL increment err_count on each cycle where err_nsmall=1 and busy=1, saturating at 16'hFFFF.
REQ-029 The pending counter SHALL clear on valid acceptance and on stop.

Reset
REQ-030 areset=1 at an edge SHALL force IDLE and drive ramp=0, busy=0, done=0, cfg_err=0, overrun=0, chirp_count=0, err_count=0, nfft=0 and pending=0, including mid-burst.
REQ-031 Reset SHALL take priority over start and stop in the same cycle.

Verification
REQ-032 Nominal case: period=10, ramp_len=6, nchirps=3, nfft=8, start pulse at t -> ramp high t+1..t+6, t+11..t+16 and t+21..t+26; done=1 at t+31; chirp_count=3; nfft=8 from t+1.
REQ-033 Invalid configuration: period=6, ramp_len=6, start -> cfg_err=1 for one cycle, busy stays 0, nfft unchanged.
REQ-034 Abort: stop at the third ramp cycle of chirp 2 -> ramp=0 and busy=0 on the next cycle, no done pulse, chirp_count=2.
REQ-035 Overrun: nchirps=4 with frame_done never asserted -> overrun=1 from the third RAMP entry onward.
REQ-036 Error counting: err_nsmall held for 5 busy cycles -> err_count=5; err_nsmall asserted in IDLE -> no increment.
REQ-037 Reset mid-burst: areset asserted during GAP -> all outputs at reset values on the next cycle; a subsequent start runs the burst normally.
